dma_copy_engine: RTL

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

---
 rtl/dma_pkg.sv | 15 +
 rtl/dma_addr_gen.sv | 59 +++++
 rtl/dma_copy_engine.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA copy engine: FSM encoding and unit strides.
package dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_READ  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } dma_state_e;

   localparam int STRIDE_WORD = 4;
   localparam int STRIDE_BYTE = 1;

endpackage

// File: rtl/dma_addr_gen.sv
// Offset/count bookkeeping for the copy loop plus the up-front range and
// alignment check on both regions.
module dma_addr_gen
   import dma_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int LEN_WIDTH     = 16,
   parameter int MEM_LIMIT     = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     step,
   input  logic                     byte_mode,
   input  logic [ADDRESS_WIDTH-1:0] src_base,
   input  logic [ADDRESS_WIDTH-1:0] dst_base,
   input  logic [LEN_WIDTH-1:0]     length,
   output logic [ADDRESS_WIDTH-1:0] offset,
   output logic [LEN_WIDTH-1:0]     count,
   output logic                     last,
   output logic                     range_err
);

   logic [ADDRESS_WIDTH-1:0] stride;
   logic [ADDRESS_WIDTH:0]   len_ext;
   logic [ADDRESS_WIDTH:0]   span;
   logic [ADDRESS_WIDTH:0]   src_end;
   logic [ADDRESS_WIDTH:0]   dst_end;
   logic                     misalign;

   // End addresses carry one extra bit so a wrap past 2^AW still reads as out of range.
   always_comb begin
      stride    = byte_mode ? ADDRESS_WIDTH'(STRIDE_BYTE) : ADDRESS_WIDTH'(STRIDE_WORD);
      len_ext   = (ADDRESS_WIDTH+1)'(length);
      span      = byte_mode ? len_ext : (len_ext << 2);
      src_end   = {1'b0, src_base} + span;
      dst_end   = {1'b0, dst_base} + span;
      misalign  = !byte_mode && ((src_base[1:0] != 2'b00) || (dst_base[1:0] != 2'b00));
      range_err = misalign
                  || (src_end > (ADDRESS_WIDTH+1)'(MEM_LIMIT))
                  || (dst_end > (ADDRESS_WIDTH+1)'(MEM_LIMIT));
      last      = (count + LEN_WIDTH'(1)) == length;
   end

   // Offset and unit count restart on every accepted request and advance per write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         offset <= '0;
         count  <= '0;
      end else if (clr) begin
         offset <= '0;
         count  <= '0;
      end else if (step) begin
         offset <= offset + stride;
         count  <= count + LEN_WIDTH'(1);
      end
   end

endmodule

// File: rtl/dma_copy_engine.sv
// Single-channel memory-to-memory copier: one read then one write per unit,
// ascending addresses, byte or word granularity.
module dma_copy_engine
   import dma_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_LIMIT     = 1024,
   parameter int LEN_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH-1:0] src_addr,
   input  logic [ADDRESS_WIDTH-1:0] dst_addr,
   input  logic [LEN_WIDTH-1:0]     length,
   input  logic                     byte_mode,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]    mem_write_data,
   output logic                     mem_we,
   output logic                     mem_re,
   output logic                     mem_be,
   input  logic [DATA_WIDTH-1:0]    mem_read_data,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   dma_state_e               state;
   logic [ADDRESS_WIDTH-1:0] src_q;
   logic [ADDRESS_WIDTH-1:0] dst_q;
   logic [LEN_WIDTH-1:0]     len_q;
   logic                     bm_q;
   logic [DATA_WIDTH-1:0]    buffer;
   logic [ADDRESS_WIDTH-1:0] offset;
   logic [LEN_WIDTH-1:0]     count;
   logic                     last;
   logic                     range_err;
   logic                     accept;

   assign accept = (state == ST_IDLE) && start;

   dma_addr_gen #(
      .ADDRESS_WIDTH(ADDRESS_WIDTH),
      .LEN_WIDTH    (LEN_WIDTH),
      .MEM_LIMIT    (MEM_LIMIT)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .step     (state == ST_WRITE),
      .byte_mode(bm_q),
      .src_base (src_q),
      .dst_base (dst_q),
      .length   (len_q),
      .offset   (offset),
      .count    (count),
      .last     (last),
      .range_err(range_err)
   );

   // Control FSM, request latches and the single-unit data buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         src_q  <= '0;
         dst_q  <= '0;
         len_q  <= '0;
         bm_q   <= 1'b0;
         buffer <= '0;
         error  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  src_q <= src_addr;
                  dst_q <= dst_addr;
                  len_q <= length;
                  bm_q  <= byte_mode;
                  error <= 1'b0;
                  state <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (range_err) begin
                  error <= 1'b1;
                  state <= ST_DONE;
               end else if (len_q == '0) begin
                  state <= ST_DONE;
               end else begin
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               buffer <= bm_q ? DATA_WIDTH'(mem_read_data[7:0]) : mem_read_data;
               state  <= ST_WRITE;
            end
            ST_WRITE: state <= last ? ST_DONE : ST_READ;
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Memory port and status decode; everything idles at zero outside the copy loop.
   always_comb begin
      mem_address    = '0;
      mem_write_data = '0;
      mem_we         = 1'b0;
      mem_re         = 1'b0;
      mem_be         = 1'b0;
      busy           = (state != ST_IDLE);
      done           = (state == ST_DONE);
      if (state == ST_READ) begin
         mem_re      = 1'b1;
         mem_be      = bm_q;
         mem_address = src_q + offset;
      end else if (state == ST_WRITE) begin
         mem_we         = 1'b1;
         mem_be         = bm_q;
         mem_address    = dst_q + offset;
         mem_write_data = buffer;
      end
   end

   // Unused count bits beyond the last-unit compare are intentional.
   logic unused_ok;
   assign unused_ok = ^count;

endmodule
